sc_fetch: RTL and testbench

SC_FETCH -- requirements
Module: sc_fetch

---
 rtl/sc_fetch.sv | 141 ++++++++++++++
 tb/tb_sc_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc_fetch.sv
// Instruction fetch stage: three-state fetch FSM, next-PC selection and an optional
// ack-timeout watchdog compiled in with the FETCH_TIMEOUT_EN macro.
module sc_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_imem_req;
  logic        r_inst_valid;
  logic        r_fetch_err;

  logic [31:0] w_pc4;
  logic [31:0] w_br_offset;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_ra_target;
  logic [31:0] w_next_pc;
  logic        w_timeout;

  assign w_pc4       = r_pc + 32'd4;
  assign w_br_offset = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
  assign w_br_target = w_pc4 + w_br_offset;
  assign w_j_target  = {w_pc4[31:28], r_inst[25:0], 2'b00};
  assign w_ra_target = {ra[31:2], 2'b00};

  always_comb begin
    w_next_pc = w_pc4;
    case (pcsource)
      2'b00:   w_next_pc = w_pc4;
      2'b01:   w_next_pc = w_br_target;
      2'b10:   w_next_pc = w_ra_target;
      2'b11:   w_next_pc = w_j_target;
      default: w_next_pc = w_pc4;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_tmo_cnt;
  logic [7:0] w_tmo_cnt_inc;

  assign w_tmo_cnt_inc = r_tmo_cnt + 8'd1;
  // Counts consecutive ack-less REQ cycles; an ack on the limit cycle takes priority.
  assign w_timeout     = (r_state == REQ) && !imem_ack && (w_tmo_cnt_inc == TMO_LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tmo_cnt <= 8'd0;
    end else if ((r_state == REQ) && !imem_ack && !w_timeout) begin
      r_tmo_cnt <= w_tmo_cnt_inc;
    end else begin
      r_tmo_cnt <= 8'd0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= {RESET_PC[31:2], 2'b00};
      r_inst       <= 32'd0;
      r_imem_req   <= 1'b0;
      r_inst_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
    end else begin
      r_fetch_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state    <= REQ;
          r_imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            r_inst       <= imem_rdata;
            r_state      <= VALID;
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b1;
          end else if (w_timeout) begin
            // Drop back to IDLE so the same pc is re-requested after one idle cycle.
            r_state     <= IDLE;
            r_imem_req  <= 1'b0;
            r_fetch_err <= 1'b1;
          end
        end
        VALID: begin
          if (!stall) begin
            r_pc         <= w_next_pc;
            r_state      <= REQ;
            r_imem_req   <= 1'b1;
            r_inst_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_imem_req   <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign op         = r_inst[31:26];
  assign func       = r_inst[5:0];
  assign pc         = r_pc;
  assign pc4        = w_pc4;
  assign fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_sc_fetch.sv
// Bench for sc_fetch: directed scenarios with literal expectations, then randomized
// stall/pcsource/ack/reset traffic compared every cycle against a transaction-level model.
module tb_sc_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TMO      = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] ra = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        fetch_err;

  logic        dir_mode = 1'b1;
  logic        dir_ack = 1'b0;
  logic [31:0] dir_rdata = 32'd0;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_rdata = 32'd0;

  assign imem_ack   = dir_mode ? dir_ack : auto_ack;
  assign imem_rdata = dir_mode ? dir_rdata : auto_rdata;

  always #5 clock = ~clock;

  sc_fetch #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .pcsource(pcsource), .ra(ra),
    .inst(inst), .inst_valid(inst_valid), .op(op), .func(func),
    .pc(pc), .pc4(pc4), .fetch_err(fetch_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // Next fetch address from the architectural rules, as plain arithmetic.
  function automatic logic [31:0] target(input logic [31:0] cur_pc, input logic [31:0] cur_inst,
                                         input logic [1:0] sel, input logic [31:0] reg_ra);
    logic [31:0] p4;
    logic signed [31:0] off;
    p4  = cur_pc + 32'd4;
    off = 32'(signed'(cur_inst[15:0]));
    case (sel)
      2'd0:    return p4;
      2'd1:    return p4 + 32'(off * 4);
      2'd2:    return reg_ra & ~32'h3;
      default: return (p4 & 32'hF000_0000) | ((cur_inst & 32'h03FF_FFFF) << 2);
    endcase
  endfunction

  // Expected observable behaviour: a request outstanding, an instruction held, or neither.
  logic        m_req = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_inst = 32'd0;
  int          m_wait = 0;
  bit          m_live = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_req = 1'b0; m_valid = 1'b0; m_err = 1'b0;
      m_pc = RESET_PC; m_inst = 32'd0; m_wait = 0; m_live = 1'b1;
    end else if (m_live) begin
      m_err = 1'b0;
      if (m_valid) begin
        if (!stall) begin
          m_pc = target(m_pc, m_inst, pcsource, ra);
          m_valid = 1'b0;
          m_req = 1'b1;
        end
      end else if (m_req) begin
        if (imem_ack) begin
          m_inst = imem_rdata; m_req = 1'b0; m_valid = 1'b1; m_wait = 0;
        end else begin
          m_wait++;
`ifdef FETCH_TIMEOUT_EN
          if (m_wait == TMO) begin
            m_err = 1'b1; m_req = 1'b0; m_wait = 0;
          end
`endif
        end
      end else begin
        m_req = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      chk("m_imem_req", imem_req, m_req);
      chk("m_inst_valid", inst_valid, m_valid);
      chk("m_pc", pc, m_pc);
      chk("m_pc4", pc4, m_pc + 32'd4);
      chk("m_inst", inst, m_inst);
      chk("m_op_func", {op, func}, {m_inst[31:26], m_inst[5:0]});
      chk("m_fetch_err", fetch_err, m_err);
      if (m_req) chk("m_imem_addr", imem_addr, m_pc);
    end
  end

  // Random memory: variable latency, random data, occasional stray acks outside REQ.
  always @(posedge clock) begin
    #1;
    if (imem_req) auto_ack = ($urandom % 2) == 0;
    else          auto_ack = ($urandom % 8) == 0;
    auto_rdata = $urandom;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    step(); step();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_err", fetch_err, 1'b0);

    reset = 1'b0; dir_ack = 1'b1; dir_rdata = 32'h2008_0005;
    step();
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    step();
    chk("first_valid", inst_valid, 1'b1);
    chk("first_op", op, 6'h08);
    chk("first_pc", pc, 32'h0);
    chk("first_pc4", pc4, 32'h4);
    chk("first_inst", inst, 32'h2008_0005);

    stall = 1'b1; dir_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_inst", inst, 32'h2008_0005);
      chk("stall_pc", pc, 32'h0);
      chk("stall_valid", inst_valid, 1'b1);
      chk("stall_req", imem_req, 1'b0);
    end
    stall = 1'b0; dir_rdata = 32'h0800_0010;
    step();
    chk("unstall_req", imem_req, 1'b1);
    chk("unstall_addr", imem_addr, 32'h4);

    pcsource = 2'b11;
    step(); step();
    chk("jump40_addr", imem_addr, 32'h40);
    dir_rdata = 32'h1000_FFFF; pcsource = 2'b01;
    step(); step();
    chk("branch_addr", imem_addr, 32'h40);
    dir_rdata = 32'h0810_0000; pcsource = 2'b11;
    step(); step();
    chk("jump400000_addr", imem_addr, 32'h0040_0000);
    dir_rdata = 32'h0810_0003;
    step(); step();
    chk("jump_addr", imem_addr, 32'h0040_000C);
    pcsource = 2'b10; ra = 32'h1237;
    step(); step();
    chk("jr_addr", imem_addr, 32'h1234);

    reset = 1'b1; dir_rdata = 32'hDEAD_BEEF;
    step();
    chk("rst_ack_inst", inst, 32'h0);
    chk("rst_ack_valid", inst_valid, 1'b0);
    chk("rst_ack_req", imem_req, 1'b0);
    reset = 1'b0; dir_ack = 1'b0; pcsource = 2'b00;
    step();
    chk("refetch_req", imem_req, 1'b1);
    chk("refetch_addr", imem_addr, RESET_PC);

`ifdef FETCH_TIMEOUT_EN
    repeat (TMO - 1) step();
    chk("tmo_pre_err", fetch_err, 1'b0);
    chk("tmo_pre_req", imem_req, 1'b1);
    step();
    chk("tmo_err", fetch_err, 1'b1);
    chk("tmo_req_drop", imem_req, 1'b0);
    step();
    chk("tmo_err_pulse", fetch_err, 1'b0);
    chk("tmo_reissue", imem_req, 1'b1);
    chk("tmo_reissue_addr", imem_addr, RESET_PC);
    repeat (TMO - 1) step();
    dir_ack = 1'b1; dir_rdata = 32'h1234_5678;
    step();
    chk("tmo_ack_wins_err", fetch_err, 1'b0);
    chk("tmo_ack_wins_valid", inst_valid, 1'b1);
`else
    for (int i = 0; i < 40; i++) begin
      step();
      chk("no_tmo_err", fetch_err, 1'b0);
      chk("no_tmo_req", imem_req, 1'b1);
    end
    dir_ack = 1'b1; dir_rdata = 32'h1234_5678;
    step();
    chk("late_ack_valid", inst_valid, 1'b1);
`endif
    chk("late_ack_inst", inst, 32'h1234_5678);

    dir_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      stall    = ($urandom % 10) < 3;
      pcsource = 2'($urandom);
      ra       = $urandom;
      reset    = ($urandom % 150) == 0;
      step();
    end
    reset = 1'b0;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
